pc_fetch_sequencer: RTL and testbench

//  Sequences the program counter register: drives its pcWEN and pc_next, and requests

---
 rtl/pc_fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: drives the PC register write port (pcWEN/pc_next) and the
// instruction-memory read request. It loads RESET_PC after reset, then advances
// sequentially on each accepted instruction hit. It applies branch/jump redirects
// and freezes the PC on a hazard stall or a HALT.
// Build option: define DELAY_SLOT_EN to enable MIPS branch-delay-slot behaviour.
// In that build, each redirect is deferred by one advance.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          INSTR_BYTES = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_cur,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        pcWEN,
    output logic [31:0] pc_next,
    output logic        iREN,
    output logic        fetch_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic        pend_valid_reg;
    logic [31:0] pend_target_reg;
`ifdef DELAY_SLOT_EN
    logic        skip_reg;
`endif

    logic        advance;
    logic [31:0] seq_pc;
    logic [31:0] target_aligned;
    logic [31:0] fetch_pc;

    // A stall masks the hit completely, so nothing advances under a freeze.
    assign advance        = ihit & ~stall;
    assign seq_pc         = pc_cur + 32'(INSTR_BYTES);
    assign target_aligned = redirect_target & ~32'h0000_0003;

    // Select the next fetch address while in FETCH.
`ifdef DELAY_SLOT_EN
    // The delay slot always executes first, so a fresh redirect never bypasses it.
    assign fetch_pc = (pend_valid_reg && !skip_reg) ? pend_target_reg : seq_pc;
`else
    // A live redirect takes priority over the pending one.
    // The pending redirect takes priority over the sequential increment.
    assign fetch_pc = redirect_valid ? target_aligned :
                      pend_valid_reg ? pend_target_reg : seq_pc;
`endif

    // State and pending-redirect tracking.
    // Redirect and halt inputs only matter while in FETCH.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= ST_INIT;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= 32'h0000_0000;
`ifdef DELAY_SLOT_EN
            skip_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_INIT: begin
                    state_reg <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (advance && halt_in) begin
                        // A halt discards any redirect, whether live or pending.
                        state_reg      <= ST_HALT;
                        pend_valid_reg <= 1'b0;
`ifdef DELAY_SLOT_EN
                        skip_reg       <= 1'b0;
`endif
                    end else if (redirect_valid) begin
`ifdef DELAY_SLOT_EN
                        // An advance in the same cycle is the delay slot itself.
                        // Without that advance, the next advance is the delay slot.
                        pend_valid_reg  <= 1'b1;
                        pend_target_reg <= target_aligned;
                        skip_reg        <= ~advance;
`else
                        // If this cycle advances, the redirect is applied directly.
                        // Otherwise the target is held, and a newer redirect overwrites an older one.
                        pend_valid_reg  <= ~advance;
                        pend_target_reg <= target_aligned;
`endif
                    end else if (advance) begin
`ifdef DELAY_SLOT_EN
                        if (skip_reg) begin
                            skip_reg <= 1'b0;
                        end else begin
                            pend_valid_reg <= 1'b0;
                        end
`else
                        pend_valid_reg <= 1'b0;
`endif
                    end
                end
                default: begin
                    // HALT is left only through nRST.
                    state_reg <= ST_HALT;
                end
            endcase
        end
    end

    // Decode the PC-register controls and fetch request from state and current inputs.
    always_comb begin
        pcWEN       = 1'b0;
        pc_next     = pc_cur;
        iREN        = 1'b0;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            ST_INIT: begin
                pcWEN   = 1'b1;
                pc_next = RESET_PC;
            end
            ST_FETCH: begin
                iREN    = 1'b1;
                pc_next = fetch_pc;
                if (advance && !halt_in) begin
                    pcWEN       = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed testbench for pc_fetch_sequencer in its default build, where redirects take effect immediately.
// The bench models a simple PC register, fed by pcWEN/pc_next.
module tb_pc_fetch_sequencer;

    logic        CLK;
    logic        nRST;
    logic [31:0] pc_out;
    logic        ihit;
    logic        stall;
    logic        halt_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        pcWEN;
    logic [31:0] pc_next;
    logic        iREN;
    logic        fetch_valid;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_sequencer dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .pc_cur          (pc_out),
        .ihit            (ihit),
        .stall           (stall),
        .halt_in         (halt_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pcWEN           (pcWEN),
        .pc_next         (pc_next),
        .iREN            (iREN),
        .fetch_valid     (fetch_valid),
        .halted          (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External PC register, as the real datapath has it.
    always @(posedge CLK) begin
        if (pcWEN) pc_out <= pc_next;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; stall = 1'b0; halt_in = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pcwen",   pcWEN, 1);
        chk("rst_pcnext",  pc_next, 32'h0);
        chk("rst_iren",    iREN, 0);
        chk("rst_fvalid",  fetch_valid, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_pcout",   pc_out, 32'h0);

        // Test 1: sequential fetch with ihit always high.
        nRST = 1'b1; ihit = 1'b1; #1;
        chk("init_pcwen",  pcWEN, 1);
        chk("init_pcnext", pc_next, 32'h0);
        chk("init_iren",   iREN, 0);
        step();
        chk("seq_pc0",     pc_out, 32'h0);
        chk("seq_iren",    iREN, 1);
        chk("seq_pcnext4", pc_next, 32'h4);
        chk("seq_pcwen",   pcWEN, 1);
        chk("seq_fvalid",  fetch_valid, 1);
        step();
        chk("seq_pc4",     pc_out, 32'h4);
        chk("seq_pcnext8", pc_next, 32'h8);
        step();
        chk("seq_pc8",     pc_out, 32'h8);

        // Test 2: three miss cycles hold the PC.
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("miss_pcwen",  pcWEN, 0);
            chk("miss_iren",   iREN, 1);
            chk("miss_pcout",  pc_out, 32'h8);
            chk("miss_pcnext", pc_next, 32'hC);
            step();
        end
        ihit = 1'b1; #1;
        chk("miss_end_pcwen", pcWEN, 1);
        chk("miss_end_next",  pc_next, 32'hC);
        step();
        chk("seq_pcC",  pc_out, 32'hC);
        step();
        chk("seq_pc10", pc_out, 32'h10);

        // Test 3: redirect with hit, so the low bits are forced to zero.
        redirect_valid = 1'b1; redirect_target = 32'h103; #1;
        chk("redir_next",  pc_next, 32'h100);
        chk("redir_pcwen", pcWEN, 1);
        step();
        redirect_valid = 1'b0; #1;
        chk("redir_pcout", pc_out, 32'h100);

        // Test 4: redirects while waiting, where the newer redirect wins.
        ihit = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200; #1;
        chk("pend1_pcwen", pcWEN, 0);
        chk("pend1_next",  pc_next, 32'h200);
        step();
        redirect_valid = 1'b0; #1;
        chk("pend1_held",  pc_next, 32'h200);
        step();
        redirect_valid = 1'b1; redirect_target = 32'h300; #1;
        chk("pend2_next",  pc_next, 32'h300);
        step();
        redirect_valid = 1'b0; ihit = 1'b1; #1;
        chk("pend2_held",  pc_next, 32'h300);
        chk("pend2_pcwen", pcWEN, 1);
        step();
        chk("pend2_pcout", pc_out, 32'h300);
        chk("pend_clear",  pc_next, 32'h304);

        // Wrap from 0xFFFF_FFFC to 0.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF; #1;
        chk("wrap_redir", pc_next, 32'hFFFF_FFFC);
        step();
        redirect_valid = 1'b0; #1;
        chk("wrap_pcout", pc_out, 32'hFFFF_FFFC);
        chk("wrap_next",  pc_next, 32'h0);
        step();
        chk("wrap_pc0",   pc_out, 32'h0);

        // Stall masks ihit, and a redirect during the stall is latched.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400; #1;
        chk("stall_pcwen",  pcWEN, 0);
        chk("stall_fvalid", fetch_valid, 0);
        step();
        redirect_valid = 1'b0; #1;
        chk("stall_pcout",  pc_out, 32'h0);
        step();
        stall = 1'b0; #1;
        chk("unstall_next",  pc_next, 32'h400);
        chk("unstall_pcwen", pcWEN, 1);
        step();
        chk("unstall_pcout", pc_out, 32'h400);

        // Test 5: halt with a redirect in the same cycle, so the halt wins.
        halt_in = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h500; #1;
        chk("halt_pcwen", pcWEN, 0);
        step();
        halt_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = i[0]; redirect_target = 32'h700; #1;
            chk("halt_flag",  halted, 1);
            chk("halt_iren",  iREN, 0);
            chk("halt_pcwen", pcWEN, 0);
            chk("halt_pcout", pc_out, 32'h400);
            step();
        end
        redirect_valid = 1'b0;
        nRST = 1'b0; #1;
        chk("hrst_halted", halted, 0);
        chk("hrst_pcwen",  pcWEN, 1);
        chk("hrst_next",   pc_next, 32'h0);
        step();
        nRST = 1'b1;
        step();
        chk("restart_pc0",   pc_out, 32'h0);
        chk("restart_next4", pc_next, 32'h4);
        step();
        chk("restart_pc4",   pc_out, 32'h4);

        // Test 6: reset drops a pending redirect.
        ihit = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h600;
        step();
        redirect_valid = 1'b0; #1;
        chk("t6_pending", pc_next, 32'h600);
        nRST = 1'b0; #1;
        chk("t6_rst_next",  pc_next, 32'h0);
        chk("t6_rst_pcwen", pcWEN, 1);
        chk("t6_rst_iren",  iREN, 0);
        step();
        nRST = 1'b1;
        step();
        chk("t6_pc0", pc_out, 32'h0);
        ihit = 1'b1; #1;
        chk("t6_dropped", pc_next, 32'h4);
        step();
        chk("t6_pc4", pc_out, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
